vga_timing: RTL and testbench



---
 rtl/vga_timing_if.sv | 32 +++
 rtl/vga_timing.sv | 154 +++++++++++++++
 tb/tb_vga_timing.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// Signal bundle between vga_timing, the pixel generator and the output pins.
// test_sel is present only when VGA_TEST_PATTERN_EN is defined.
interface vga_timing_if;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       frame_start;
  logic [7:0] rgb_in;
  logic       hsync;
  logic       vsync;
  logic [7:0] rgb_out;
`ifdef VGA_TEST_PATTERN_EN
  logic       test_sel;

  modport master (
    output h_count, v_count, frame_start, hsync, vsync, rgb_out,
    input  rgb_in, test_sel
  );
  modport slave (
    input  h_count, v_count, frame_start, hsync, vsync, rgb_out,
    output rgb_in, test_sel
  );
`else
  modport master (
    output h_count, v_count, frame_start, hsync, vsync, rgb_out,
    input  rgb_in
  );
  modport slave (
    input  h_count, v_count, frame_start, hsync, vsync, rgb_out,
    output rgb_in
  );
`endif
endinterface

// File: rtl/vga_timing.sv
// 640x480@60 raster counters, sync generation and blanked/aligned RGB332 output.
// Optional colour-bar substitution is enabled with VGA_TEST_PATTERN_EN.
module vga_timing #(
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 10
) (
  input  logic         clk_25,
  input  logic         rst_n,
  vga_timing_if.master vga
);

  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;

  localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
  localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_BEG  = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_ACT_END  = 10'(H_SYNC + H_BP + H_ACT);
  localparam logic [9:0] V_ACT_BEG  = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_ACT_END  = 10'(V_SYNC + V_BP + V_ACT);

  logic       r_started;
  logic [9:0] r_h_count;
  logic [9:0] r_v_count;
  logic       r_frame_start;
  logic [9:0] w_h_next;
  logic [9:0] w_v_next;

  logic       w_hs0;
  logic       w_vs0;
  logic       w_act0;
  logic       r_hs1;
  logic       r_vs1;
  logic       r_act1;
  logic       r_hsync;
  logic       r_vsync;
  logic [7:0] r_rgb_out;
  logic [7:0] w_pix1;

  // The first edge after reset release only loads (0,0); counting starts on the next one.
  always_comb begin
    w_h_next = '0;
    w_v_next = '0;
    if (r_started) begin
      if (r_h_count == H_LAST) begin
        w_h_next = '0;
        w_v_next = (r_v_count == V_LAST) ? '0 : r_v_count + 10'd1;
      end else begin
        w_h_next = r_h_count + 10'd1;
        w_v_next = r_v_count;
      end
    end
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_started     <= 1'b0;
      r_h_count     <= '0;
      r_v_count     <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_started     <= 1'b1;
      r_h_count     <= w_h_next;
      r_v_count     <= w_v_next;
      r_frame_start <= (w_h_next == '0) && (w_v_next == '0);
    end
  end

  assign w_hs0  = (r_h_count < H_SYNC_END);
  assign w_vs0  = (r_v_count < V_SYNC_END);
  assign w_act0 = (r_h_count >= H_ACT_BEG) && (r_h_count < H_ACT_END) &&
                  (r_v_count >= V_ACT_BEG) && (r_v_count < V_ACT_END);

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'(H_ACT / 8);

  logic [9:0] w_h_off;
  logic [2:0] w_bar0;
  logic [2:0] r_bar1;
  logic       r_tsel1;

  assign w_h_off = r_h_count - H_ACT_BEG;
  assign w_bar0  = 3'(w_h_off / BAR_W);

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_bar1  <= '0;
      r_tsel1 <= 1'b0;
    end else begin
      r_bar1  <= w_bar0;
      r_tsel1 <= vga.test_sel;
    end
  end
`endif

  // Stage-1 decodes are gated until counting starts so the load cycle never reaches the pins.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_hs1  <= 1'b0;
      r_vs1  <= 1'b0;
      r_act1 <= 1'b0;
    end else begin
      r_hs1  <= w_hs0 & r_started;
      r_vs1  <= w_vs0 & r_started;
      r_act1 <= w_act0 & r_started;
    end
  end

  always_comb begin
    w_pix1 = vga.rgb_in;
`ifdef VGA_TEST_PATTERN_EN
    if (r_tsel1) begin
      case (r_bar1)
        3'd0:    w_pix1 = 8'hFF;
        3'd1:    w_pix1 = 8'hFC;
        3'd2:    w_pix1 = 8'h1F;
        3'd3:    w_pix1 = 8'h1C;
        3'd4:    w_pix1 = 8'hE3;
        3'd5:    w_pix1 = 8'hE0;
        3'd6:    w_pix1 = 8'h03;
        default: w_pix1 = 8'h00;
      endcase
    end
`endif
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync   <= 1'b1;
      r_vsync   <= 1'b1;
      r_rgb_out <= 8'h00;
    end else begin
      r_hsync   <= ~r_hs1;
      r_vsync   <= ~r_vs1;
      r_rgb_out <= r_act1 ? w_pix1 : 8'h00;
    end
  end

  assign vga.h_count     = r_h_count;
  assign vga.v_count     = r_v_count;
  assign vga.frame_start = r_frame_start;
  assign vga.hsync       = r_hsync;
  assign vga.vsync       = r_vsync;
  assign vga.rgb_out     = r_rgb_out;

endmodule

// File: tb/tb_vga_timing.sv
// Randomized scoreboard bench for vga_timing: a full-size raster plus a shrunken one
// so frame wrap is reached quickly. Define VGA_TEST_PATTERN_EN to cover colour bars.
`timescale 1ns/1ps
module tb_vga_timing;

  localparam int FH_SYNC = 96, FH_BP = 48, FH_ACT = 640, FH_FP = 16;
  localparam int FV_SYNC = 2,  FV_BP = 33, FV_ACT = 480, FV_FP = 10;
  localparam int SH_SYNC = 8,  SH_BP = 6,  SH_ACT = 32,  SH_FP = 4;
  localparam int SV_SYNC = 2,  SV_BP = 3,  SV_ACT = 6,   SV_FP = 2;
  localparam int FULL_H  = FH_SYNC + FH_BP + FH_ACT + FH_FP;
  localparam int FULL_V  = FV_SYNC + FV_BP + FV_ACT + FV_FP;
  // The first run ends on pixel (400,36) of the full raster, inside the active window.
  localparam int RUN1 = 36 * FULL_H + 400;
  localparam int RUN2 = 1800;
  localparam int MAX_FAIL_PRINTS = 20;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       fs;
    logic       hsync;
    logic       vsync;
    logic [7:0] rgb;
  } exp_t;

  logic clk_25 = 1'b0;
  logic rst_n;

  vga_timing_if busA ();
  vga_timing_if busB ();

  vga_timing u_dutFull (
    .clk_25 (clk_25),
    .rst_n  (rst_n),
    .vga    (busA)
  );

  vga_timing #(
    .H_SYNC (SH_SYNC), .H_BP (SH_BP), .H_ACT (SH_ACT), .H_FP (SH_FP),
    .V_SYNC (SV_SYNC), .V_BP (SV_BP), .V_ACT (SV_ACT), .V_FP (SV_FP)
  ) u_dutSmall (
    .clk_25 (clk_25),
    .rst_n  (rst_n),
    .vga    (busB)
  );

  always #20 clk_25 = ~clk_25;

  exp_t       qA[$];
  exp_t       qB[$];
  logic [7:0] dataHist [int];
  logic       tselHist [int];
  logic       lineSel = 1'b0;
  int         checks = 0;
  int         errors = 0;

  function automatic logic [7:0] barColour(input int idx);
    case (idx)
      0:       return 8'hFF;
      1:       return 8'hFC;
      2:       return 8'h1F;
      3:       return 8'h1C;
      4:       return 8'hE3;
      5:       return 8'hE0;
      6:       return 8'h03;
      default: return 8'h00;
    endcase
  endfunction

  // Pixel data mixes h-low-byte lines (alignment), constant A5 lines (blanking) and random lines.
  function automatic logic [7:0] pickData(input int p);
    int ph, pv;
    ph = p % FULL_H;
    pv = (p / FULL_H) % FULL_V;
    case (pv % 4)
      1, 3:    return 8'(ph);
      2:       return 8'hA5;
      default: return 8'($urandom);
    endcase
  endfunction

  // Expected outputs in cycle k after counting starts; pins carry pixel k-2.
  function automatic exp_t modelAt(input int k, input int hs, hb, ha, hf, vs, vb, va, vf);
    exp_t       e;
    int         hTot, vTot, p, ph, pv;
    logic       act;
    logic [7:0] colour;
    hTot    = hs + hb + ha + hf;
    vTot    = vs + vb + va + vf;
    e.h     = 10'(k % hTot);
    e.v     = 10'((k / hTot) % vTot);
    e.fs    = ((k % (hTot * vTot)) == 0);
    e.hsync = 1'b1;
    e.vsync = 1'b1;
    e.rgb   = 8'h00;
    if (k >= 2) begin
      p       = k - 2;
      ph      = p % hTot;
      pv      = (p / hTot) % vTot;
      e.hsync = (ph >= hs);
      e.vsync = (pv >= vs);
      act     = (ph >= hs + hb) && (ph < hs + hb + ha) && (pv >= vs + vb) && (pv < vs + vb + va);
      colour  = dataHist[p];
      if (tselHist[p]) colour = barColour((ph - hs - hb) / (ha / 8));
      e.rgb   = act ? colour : 8'h00;
    end
    return e;
  endfunction

  task automatic pushReset();
    exp_t e;
    e.h = '0; e.v = '0; e.fs = 1'b0; e.hsync = 1'b1; e.vsync = 1'b1; e.rgb = 8'h00;
    qA.push_back(e);
    qB.push_back(e);
  endtask

  // Drives cycle k: test_sel for pixel k, rgb_in for pixel k-1; queues both expectations.
  task automatic applyStimulus(input int k);
    logic [7:0] d;
    logic       t;
    t = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
    if (k % FULL_H == 0) lineSel = 1'($urandom_range(0, 1));
    t = lineSel;
    busA.test_sel = t;
    busB.test_sel = t;
`endif
    tselHist[k] = t;
    d = 8'($urandom);
    if (k >= 1) begin
      d = pickData(k - 1);
      dataHist[k - 1] = d;
    end
    busA.rgb_in = d;
    busB.rgb_in = d;
    qA.push_back(modelAt(k, FH_SYNC, FH_BP, FH_ACT, FH_FP, FV_SYNC, FV_BP, FV_ACT, FV_FP));
    qB.push_back(modelAt(k, SH_SYNC, SH_BP, SH_ACT, SH_FP, SV_SYNC, SV_BP, SV_ACT, SV_FP));
  endtask

  task automatic runCycles(input int n);
    dataHist.delete();
    tselHist.delete();
    for (int k = 0; k < n; k++) begin
      @(posedge clk_25);
      #1;
      applyStimulus(k);
    end
  endtask

  // Holds reset across n edges, releasing mid-cycle in the last one.
  task automatic holdReset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_25);
      #1;
      pushReset();
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic compareField(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= MAX_FAIL_PRINTS)
        $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input exp_t e,
                             input logic [9:0] h, v, input logic fs, hs, vs,
                             input logic [7:0] rgb);
    compareField({tag, ".h_count"},     h,       e.h);
    compareField({tag, ".v_count"},     v,       e.v);
    compareField({tag, ".frame_start"}, 10'(fs),  10'(e.fs));
    compareField({tag, ".hsync"},       10'(hs),  10'(e.hsync));
    compareField({tag, ".vsync"},       10'(vs),  10'(e.vsync));
    compareField({tag, ".rgb_out"},     10'(rgb), 10'(e.rgb));
  endtask

  // Monitor: compares each presented output cycle against the oldest queued expectation.
  always @(negedge clk_25) begin
    if (qA.size() > 0)
      checkOutput("full", qA.pop_front(), busA.h_count, busA.v_count, busA.frame_start,
                  busA.hsync, busA.vsync, busA.rgb_out);
    if (qB.size() > 0)
      checkOutput("small", qB.pop_front(), busB.h_count, busB.v_count, busB.frame_start,
                  busB.hsync, busB.vsync, busB.rgb_out);
  end

  initial begin
    #(40 * 40000);
    $display("[TB] FAIL watchdog: got timeout expected completion at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    busA.rgb_in = 8'h00;
    busB.rgb_in = 8'h00;
`ifdef VGA_TEST_PATTERN_EN
    busA.test_sel = 1'b0;
    busB.test_sel = 1'b0;
`endif
    $display("[TB] reset, then %0d cycles", RUN1);
    holdReset(3);
    runCycles(RUN1);

    // Asynchronous reset in the middle of an active line, visible before the next edge.
    $display("[TB] mid-frame reset");
    @(posedge clk_25);
    #1;
    pushReset();
    #1 rst_n = 1'b0;
    holdReset(3);
    runCycles(RUN2);

    @(negedge clk_25);
    #1;
    checks++;
    if (qA.size() + qB.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", qA.size() + qB.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
